// File: rtl/lpddr2_pkg.sv
// Shared types and constants for the LPDDR2 Avalon bridge.
package lpddr2_pkg;

  localparam int DDR_ADDR_W = 27;
  localparam int DDR_DATA_W = 32;

  // Cache data after a read timeout, so a stuck read is easy to spot downstream.
  localparam logic [DDR_DATA_W-1:0] TIMEOUT_POISON = 32'hDEADBEEF;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    WR,
    RD,
    RD_WAIT
  } state_t;

endpackage

// File: rtl/lpddr2_bridge.sv
// Core-side request to Avalon-MM master bridge with a one-entry read cache
// and a read-response timeout.
module lpddr2_bridge
  import lpddr2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DDR_ADDR_W-1:0] address,
  input  logic [DDR_DATA_W-1:0] write_data,
  input  logic                  read_req,
  input  logic                  write_req,
  output logic [DDR_DATA_W-1:0] read_data,
  output logic                  busy,
  output logic                  err_timeout,
  input  logic                  avl_ready,
  output logic [DDR_ADDR_W-1:0] avl_addr,
  output logic [DDR_DATA_W-1:0] avl_wdata,
  output logic [3:0]            avl_be,
  output logic                  avl_read,
  output logic                  avl_write,
  input  logic                  avl_waitrequest,
  input  logic [DDR_DATA_W-1:0] avl_rdata,
  input  logic                  avl_rdata_valid
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                state_reg, state_next;
  logic                  cache_valid_reg;
  logic [DDR_ADDR_W-1:0] cache_tag_reg;
  logic [DDR_DATA_W-1:0] cache_data_reg;
  logic [CNT_W-1:0]      tmo_cnt_reg;
  logic                  err_timeout_reg;
  logic                  avl_read_reg, avl_write_reg;
  logic [DDR_ADDR_W-1:0] avl_addr_reg;
  logic [DDR_DATA_W-1:0] avl_wdata_reg;

  logic hit, tmo_expire, tag_match;

  assign tag_match  = cache_valid_reg & (cache_tag_reg == address);
  assign hit        = (state_reg == IDLE) & read_req & tag_match;
  assign tmo_expire = (state_reg == RD_WAIT) & ~avl_rdata_valid & (tmo_cnt_reg == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= INIT;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      INIT:    if (avl_ready) state_next = IDLE;
      IDLE: begin
        // Writes win over a simultaneous read; the read is served afterwards.
        if (write_req)              state_next = WR;
        else if (read_req && !hit)  state_next = RD;
      end
      WR:      if (!avl_waitrequest) state_next = IDLE;
      RD:      if (!avl_waitrequest) state_next = RD_WAIT;
      RD_WAIT: if (avl_rdata_valid || tmo_expire) state_next = IDLE;
      default: state_next = INIT;
    endcase
  end

  always_comb begin
    busy = 1'b1;
    if (state_reg == IDLE) busy = write_req | (read_req & ~hit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cache_valid_reg <= 1'b0;
      cache_tag_reg   <= '0;
      cache_data_reg  <= '0;
      tmo_cnt_reg     <= '0;
      err_timeout_reg <= 1'b0;
      avl_read_reg    <= 1'b0;
      avl_write_reg   <= 1'b0;
      avl_addr_reg    <= '0;
      avl_wdata_reg   <= '0;
    end else begin
      // Strobes follow the next state, so they can never overlap.
      avl_read_reg  <= (state_next == RD);
      avl_write_reg <= (state_next == WR);

      if (state_reg == IDLE && write_req) begin
        avl_addr_reg  <= address;
        avl_wdata_reg <= write_data;
        if (tag_match) cache_data_reg <= write_data;
      end else if (state_reg == IDLE && read_req && !hit) begin
        avl_addr_reg <= address;
      end

      if (state_reg == RD_WAIT) begin
        if (avl_rdata_valid) begin
          cache_valid_reg <= 1'b1;
          cache_tag_reg   <= avl_addr_reg;
          cache_data_reg  <= avl_rdata;
          tmo_cnt_reg     <= '0;
        end else if (tmo_expire) begin
          cache_valid_reg <= 1'b0;
          cache_data_reg  <= TIMEOUT_POISON;
          err_timeout_reg <= 1'b1;
          tmo_cnt_reg     <= '0;
        end else begin
          tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
        end
      end else begin
        tmo_cnt_reg <= '0;
      end
    end
  end

  assign read_data   = cache_data_reg;
  assign err_timeout = err_timeout_reg;
  assign avl_addr    = avl_addr_reg;
  assign avl_wdata   = avl_wdata_reg;
  assign avl_be      = 4'hF;
  assign avl_read    = avl_read_reg;
  assign avl_write   = avl_write_reg;

endmodule

// File: tb/tb_lpddr2_bridge.sv
// Randomised bench for lpddr2_bridge: an Avalon slave with variable wait states
// and latency, plus a cache/memory reference model kept at transaction level.
module tb_lpddr2_bridge;
  import lpddr2_pkg::*;

  localparam int TMO = 8;
  localparam int BOUND = 100;

  logic        clk = 1'b0, rst = 1'b1;
  logic [26:0] address = '0;
  logic [31:0] write_data = '0;
  logic        read_req = 1'b0, write_req = 1'b0;
  logic [31:0] read_data;
  logic        busy, err_timeout;
  logic        avl_ready = 1'b0;
  logic [26:0] avl_addr;
  logic [31:0] avl_wdata;
  logic [3:0]  avl_be;
  logic        avl_read, avl_write;
  logic        avl_waitrequest = 1'b0;
  logic [31:0] avl_rdata = '0;
  logic        avl_rdata_valid = 1'b0;

  lpddr2_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .address(address), .write_data(write_data),
    .read_req(read_req), .write_req(write_req), .read_data(read_data),
    .busy(busy), .err_timeout(err_timeout), .avl_ready(avl_ready),
    .avl_addr(avl_addr), .avl_wdata(avl_wdata), .avl_be(avl_be),
    .avl_read(avl_read), .avl_write(avl_write),
    .avl_waitrequest(avl_waitrequest), .avl_rdata(avl_rdata),
    .avl_rdata_valid(avl_rdata_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bg(input logic [26:0] a);
    return (32'(a) * 32'h9E3779B1) ^ 32'hC3C3C3C3;
  endfunction

  // Reference model: memory contents as written by the core, plus the cache.
  logic [31:0] ref_mem [logic [26:0]];
  logic [31:0] slv_mem [logic [26:0]];
  bit          m_valid = 0, m_err = 0;
  logic [26:0] m_tag = '0;
  logic [31:0] m_data = '0;

  function automatic logic [31:0] ref_rd(input logic [26:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : bg(a);
  endfunction

  // Avalon slave
  int next_ws = 0, next_lat = 0;
  bit no_resp = 0;
  int ws_left = 0, resp_delay = 0;
  bit in_cmd = 0, resp_pending = 0;
  logic [26:0] resp_addr = '0;
  int rd_pulses = 0, rd_cycles = 0, wr_pulses = 0, wr_cycles = 0;
  int cyc = 0, acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    avl_rdata_valid = 1'b0;
    if (resp_pending) begin
      if (resp_delay == 0) begin
        avl_rdata_valid = 1'b1;
        avl_rdata = slv_mem.exists(resp_addr) ? slv_mem[resp_addr] : bg(resp_addr);
        resp_pending = 0;
      end else resp_delay--;
    end
    if (avl_read && avl_write) check("rw_exclusive", 1, 0);
    if (avl_read) rd_cycles++;
    if (avl_write) wr_cycles++;
    if (avl_read || avl_write) begin
      if (!in_cmd) begin
        in_cmd = 1;
        ws_left = next_ws;
        if (avl_read) rd_pulses++; else wr_pulses++;
      end
      if (ws_left > 0) begin
        avl_waitrequest = 1'b1;
        ws_left--;
      end else begin
        avl_waitrequest = 1'b0;
        in_cmd = 0;
        acc_cyc = cyc + 1;
        if (avl_read) begin
          resp_pending = !no_resp;
          resp_delay = next_lat;
          resp_addr = avl_addr;
        end else slv_mem[avl_addr] = avl_wdata;
      end
    end else begin
      avl_waitrequest = 1'b0;
      in_cmd = 0;
    end
  end

  task automatic do_read(input logic [26:0] a, input string tag);
    bit exp_hit;
    int rp0, n;
    @(negedge clk);
    exp_hit = m_valid && (m_tag == a);
    rp0 = rd_pulses;
    address = a;
    read_req = 1'b1;
    #1;
    check({tag, "_busy"}, busy, !exp_hit);
    n = 0;
    if (no_resp) begin
      while (!err_timeout && n < BOUND) begin @(negedge clk); #1; n++; end
      check({tag, "_tmo_cycles"}, cyc - acc_cyc, TMO);
      check({tag, "_tmo_busy"}, busy, 1);
      m_valid = 0;
      m_data = TIMEOUT_POISON;
      m_err = 1;
    end else begin
      while (busy && n < BOUND) begin @(negedge clk); #1; n++; end
      if (!exp_hit) begin
        m_valid = 1;
        m_tag = a;
        m_data = ref_rd(a);
      end
    end
    read_req = 1'b0;
    check({tag, "_bound"}, n < BOUND, 1);
    check({tag, "_data"}, read_data, m_data);
    check({tag, "_avl_reads"}, rd_pulses - rp0, exp_hit ? 0 : 1);
    check({tag, "_err"}, err_timeout, m_err);
    $display("rd %-10s addr=0x%07h hit=%0d data=0x%08h", tag, a, exp_hit, read_data);
  endtask

  task automatic do_write(input logic [26:0] a, input logic [31:0] d, input string tag);
    int wp0, n;
    bit seen;
    @(negedge clk);
    wp0 = wr_pulses;
    address = a;
    write_data = d;
    write_req = 1'b1;
    #1;
    check({tag, "_busy"}, busy, 1);
    seen = 0;
    n = 0;
    while (!(seen && !avl_write) && n < BOUND) begin
      @(negedge clk); #1;
      if (avl_write) seen = 1;
      n++;
    end
    write_req = 1'b0;
    ref_mem[a] = d;
    if (m_valid && m_tag == a) m_data = d;
    check({tag, "_bound"}, n < BOUND, 1);
    check({tag, "_avl_writes"}, wr_pulses - wp0, 1);
    check({tag, "_addr"}, avl_addr, a);
    check({tag, "_wdata"}, avl_wdata, d);
    check({tag, "_data"}, read_data, m_data);
    $display("wr %-10s addr=0x%07h data=0x%08h", tag, a, d);
  endtask

  task automatic wait_accept(input string tag);
    int n = 0;
    while (!avl_read && n < BOUND) begin @(negedge clk); #1; n++; end
    while (avl_read && n < BOUND) begin @(negedge clk); #1; n++; end
    check({tag, "_accept_bound"}, n < BOUND, 1);
  endtask

  int rc0, wc0, rp0, nb, n;
  bit seen;

  initial begin
    slv_mem[27'h100] = 32'hCAFEF00D;
    ref_mem[27'h100] = 32'hCAFEF00D;

    // Reset and calibration wait: requests pending, no traffic allowed.
    read_req = 1'b1;
    write_req = 1'b1;
    address = 27'h100;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 2) rst = 1'b0;
      #1;
      check("init_busy", busy, 1);
      check("init_no_traffic", {avl_read, avl_write}, 2'b00);
    end
    check("rst_read_data", read_data, 0);
    check("rst_err", err_timeout, 0);
    check("rst_avl_addr", avl_addr, 0);
    check("rst_avl_wdata", avl_wdata, 0);
    check("avl_be", avl_be, 4'hF);
    @(negedge clk);
    read_req = 1'b0;
    write_req = 1'b0;
    avl_ready = 1'b1;
    @(negedge clk); #1;
    check("idle_after_ready", busy, 0);
    $display("init done");

    // Fill with two wait states: avl_read held three cycles.
    next_ws = 2;
    next_lat = 2;
    rc0 = rd_cycles;
    do_read(27'h100, "fill");
    check("fill_rd_cycles", rd_cycles - rc0, 3);

    // Repeated hits generate no traffic.
    @(negedge clk);
    rp0 = rd_pulses;
    nb = 0;
    address = 27'h100;
    read_req = 1'b1;
    for (int i = 0; i < 20; i++) begin #1; if (busy) nb++; @(negedge clk); end
    read_req = 1'b0;
    check("hits_busy", nb, 0);
    check("hits_reads", rd_pulses - rp0, 0);
    check("hits_data", read_data, 32'hCAFEF00D);
    $display("rd hit-burst addr=0x0000100 x20 data=0x%08h", read_data);

    // Write-through to the cached line.
    next_ws = 0;
    wc0 = wr_cycles;
    do_write(27'h100, 32'h12345678, "wthru");
    check("wthru_wr_cycles", wr_cycles - wc0, 1);
    do_read(27'h100, "wthru_rd");

    // Simultaneous read and write: write first, then the read miss.
    @(negedge clk);
    rp0 = rd_pulses;
    address = 27'h200;
    write_data = 32'hA5A50200;
    write_req = 1'b1;
    read_req = 1'b1;
    seen = 0;
    n = 0;
    while (!(seen && !avl_write) && n < BOUND) begin
      @(negedge clk); #1;
      if (avl_write) seen = 1;
      n++;
    end
    check("rw_write_first", rd_pulses - rp0, 0);
    write_req = 1'b0;
    ref_mem[27'h200] = 32'hA5A50200;
    while (busy && n < BOUND) begin @(negedge clk); #1; n++; end
    read_req = 1'b0;
    check("rw_bound", n < BOUND, 1);
    check("rw_read_after", rd_pulses - rp0, 1);
    check("rw_data", read_data, 32'hA5A50200);
    m_valid = 1;
    m_tag = 27'h200;
    m_data = 32'hA5A50200;
    $display("rw addr=0x0000200 data=0x%08h", read_data);

    // Random traffic over a small address window.
    for (int i = 0; i < 80; i++) begin
      logic [26:0] a;
      a = 27'h300 + 27'($urandom_range(0, 5));
      next_ws = $urandom_range(0, 2);
      next_lat = $urandom_range(0, 4);
      if ($urandom_range(0, 2) == 0) do_write(a, $urandom, "rand_wr");
      else do_read(a, "rand_rd");
    end

    // Read timeout, then the same address misses again.
    next_ws = 1;
    next_lat = 1;
    no_resp = 1;
    do_read(27'h400, "timeout");
    no_resp = 0;
    do_read(27'h400, "after_tmo");

    // Reset while the read command is still being presented.
    next_ws = 6;
    @(negedge clk);
    address = 27'h500;
    read_req = 1'b1;
    n = 0;
    while (!avl_read && n < BOUND) begin @(negedge clk); #1; n++; end
    rst = 1'b1;
    read_req = 1'b0;
    @(negedge clk); #1;
    check("rst_rd_drop", avl_read, 0);
    check("rst_rd_busy", busy, 1);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Reset while waiting for the response; the late data must be dropped.
    next_ws = 0;
    next_lat = 3;
    @(negedge clk);
    address = 27'h500;
    read_req = 1'b1;
    wait_accept("rst_wait");
    rst = 1'b1;
    read_req = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0;
    check("rst_wait_data", read_data, 0);
    check("rst_wait_err", err_timeout, 0);
    repeat (8) @(negedge clk);
    #1;
    check("rst_discard", read_data, 0);
    m_valid = 0;
    m_data = '0;
    m_err = 0;
    $display("rst mid-read addr=0x0000500 data=0x%08h", read_data);
    do_read(27'h500, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
